stream_fifo: RTL and testbench

//  Parametrised valid/ready buffer between two stream_if interface instances.

---
 rtl/stream_pkg.sv | 13 +
 rtl/stream_if.sv | 8 +
 rtl/stream_fifo_ram.sv | 19 +
 rtl/stream_fifo.sv | 75 +++++++
 tb/tb_stream_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: shared types and sizing helpers for the stream_fifo slice.
package stream_pkg;

    function automatic int clog2_ptr(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

endpackage

// File: rtl/stream_if.sv
// stream_if: valid/ready/data stream bundle with producer (source) and consumer (sink) views.
interface stream_if #(parameter int WIDTH = 8);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport source (output valid, data, input ready);
    modport sink   (input valid, data, output ready);
endinterface

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram: write-enabled register array with asynchronous read; contents are never reset.
module stream_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: DEPTH-entry valid/ready buffer between two stream_if ports.
// Define STREAM_FIFO_FALLTHROUGH_EN for a zero-latency bypass when the buffer is empty.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stream_if.sink                 up,
    stream_if.source               dn,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [clog2_ptr(DEPTH)-1:0] ptr_t;

    ptr_t             wr_ptr, rd_ptr;
    logic             empty, full, push, pop, we, bypass;
    logic [WIDTH-1:0] rdata;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("stream_fifo: DEPTH must be a power of two >= 2");
    end
    if ($bits(up.data) != WIDTH || $bits(dn.data) != WIDTH) begin : g_width_chk
        $error("stream_fifo: interface WIDTH does not match WIDTH");
    end

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign up.ready = !full && !flush && rst_n;
    assign push     = up.valid && up.ready;
    assign pop      = dn.valid && dn.ready;

`ifdef STREAM_FIFO_FALLTHROUGH_EN
    // An empty buffer presents the incoming word directly; if it is taken at once it never touches storage.
    assign bypass   = empty && push && dn.ready;
    assign dn.valid = empty ? (up.valid && !flush && rst_n) : 1'b1;
    assign dn.data  = empty ? up.data : rdata;
`else
    assign bypass   = 1'b0;
    assign dn.valid = !empty;
    assign dn.data  = rdata;
`endif

    assign we    = push && !bypass;
    assign level = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (we) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !bypass) rd_ptr <= rd_ptr + 1'b1;
        end

    stream_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (up.data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // A stalled output word must stay put until the consumer takes it.
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        dn.valid && !dn.ready && !flush |=> dn.valid && $stable(dn.data))
        else $error("stream_fifo: dn word changed while stalled");
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: table vectors, directed corner sequences and a randomized queue-model run for stream_fifo.
module tb_stream_fifo;
`ifdef STREAM_FIFO_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif
    localparam int DEPTH = 4;

    typedef struct {
        logic       uv;
        logic [7:0] d;
        logic       dr;
        logic       fl;
        int         lv;
        logic       ur;
        logic       dv;
        logic       dd_chk;
        logic [7:0] dd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] level;
    int         checks = 0;
    int         errors = 0;

    stream_if #(.WIDTH(8)) up_if ();
    stream_if #(.WIDTH(8)) dn_if ();

    stream_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up_if),
        .dn    (dn_if),
        .flush (flush),
        .level (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic uv, input logic [7:0] d, input logic dr, input logic fl);
        up_if.valid = uv;
        up_if.data  = d;
        dn_if.ready = dr;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    vec_t       tbl[21];
    logic [7:0] seq[12];
    logic [7:0] q[$];

    initial begin
        up_if.valid = 1'b0;
        up_if.data  = 8'h00;
        dn_if.ready = 1'b0;
        #2;
        chk("reset_level", 32'(level), 0);
        chk("reset_dn_valid", 32'(dn_if.valid), 0);
        chk("reset_up_ready", 32'(up_if.ready), 0);
        tick();
        rst_n = 1'b1;

        // tests 1 and 2: fill, drain, full backpressure with a held fifth word
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 0, 1'b1, FT,   FT,   8'h11};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 0, 1'b1, FT,   FT,   8'hA1};
        tbl[9]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'hA1};
        tbl[10] = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'hA1};
        tbl[11] = '{1'b1, 8'hA4, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'hA1};
        tbl[12] = '{1'b1, 8'hA5, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[13] = '{1'b1, 8'hA5, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[14] = '{1'b1, 8'hA5, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[15] = '{1'b1, 8'hA5, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'hA2};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1, 8'hA2};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'hA3};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'hA4};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        foreach (tbl[i]) begin
            drive(tbl[i].uv, tbl[i].d, tbl[i].dr, tbl[i].fl);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lv));
            chk($sformatf("vec%0d_up_ready", i), 32'(up_if.ready), 32'(tbl[i].ur));
            chk($sformatf("vec%0d_dn_valid", i), 32'(dn_if.valid), 32'(tbl[i].dv));
            if (tbl[i].dd_chk) chk($sformatf("vec%0d_dn_data", i), 32'(dn_if.data), 32'(tbl[i].dd));
            tick();
        end

        // test 3: level 2, simultaneous push/pop for 10 cycles, pointers wrap
        seq[0] = 8'hB0;
        seq[1] = 8'hB1;
        for (int i = 0; i < 10; i++) seq[i+2] = 8'hC0 + 8'(i);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, seq[i], 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, seq[i+2], 1'b1, 1'b0);
            chk($sformatf("pp%0d_level", i), 32'(level), 2);
            chk($sformatf("pp%0d_data", i), 32'(dn_if.data), 32'(seq[i]));
            tick();
        end
        for (int i = 10; i < 12; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("pp_drain%0d_data", i), 32'(dn_if.data), 32'(seq[i]));
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pp_empty_level", 32'(level), 0);

        // test 4: flush at level 3 with a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_level_before", 32'(level), 3);
        chk("flush_up_ready", 32'(up_if.ready), 0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_level_after", 32'(level), 0);
        chk("flush_dn_valid", 32'(dn_if.valid), 0);
        tick();
        chk("flush_discarded", 32'(level), 0);

        // test 5: async reset mid-stream
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("prereset_level", 32'(level), 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_dn_valid", 32'(dn_if.valid), 0);
        chk("async_rst_up_ready", 32'(up_if.ready), 0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("post_rst_up_ready", 32'(up_if.ready), 1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_dn_valid", 32'(dn_if.valid), 1);
        chk("post_rst_dn_data", 32'(dn_if.data), 32'h00A5);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_drained", 32'(level), 0);

        // test 6: empty buffer, word offered with consumer ready
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("ft_dn_valid", 32'(dn_if.valid), 32'(FT));
        if (FT) chk("ft_dn_data", 32'(dn_if.data), 32'h005A);
        chk("ft_level", 32'(level), 0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ft_next_level", 32'(level), FT ? 0 : 1);
        chk("ft_next_dn_valid", 32'(dn_if.valid), 32'(!FT));
        if (!FT) chk("ft_next_dn_data", 32'(dn_if.data), 32'h005A);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ft_final_level", 32'(level), 0);

        // randomized run against a queue model
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic       uv, dr, fl, er, ev, psh, pp;
            logic [7:0] d;
            int         n;
            uv = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            d  = 8'($urandom);
            drive(uv, d, dr, fl);
            n  = q.size();
            er = (n < DEPTH) && !fl;
            ev = (n > 0) || (FT && !fl && uv);
            chk("rnd_level", 32'(level), 32'(n));
            chk("rnd_up_ready", 32'(up_if.ready), 32'(er));
            chk("rnd_dn_valid", 32'(dn_if.valid), 32'(ev));
            if (ev) chk("rnd_dn_data", 32'(dn_if.data), 32'((n > 0) ? q[0] : d));
            if (fl) q.delete();
            else begin
                psh = uv && er;
                pp  = ev && dr;
                if (!(n == 0 && psh && pp)) begin
                    if (pp) void'(q.pop_front());
                    if (psh) q.push_back(d);
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
